// File: rtl/modrm_ea_unit_pkg.sv
// rtl/modrm_ea_unit_pkg.sv - shared types and ModR/M field helpers for the EA unit
package modrm_ea_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MODRM,
        DISP_LO,
        DISP_HI,
        CALC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SEG_ES = 2'd0,
        SEG_CS = 2'd1,
        SEG_SS = 2'd2,
        SEG_DS = 2'd3
    } seg_e;

    // x86 16-bit register encoding used by the register file read ports
    typedef enum logic [2:0] {
        AX = 3'd0,
        CX = 3'd1,
        DX = 3'd2,
        BX = 3'd3,
        SP = 3'd4,
        BP = 3'd5,
        SI = 3'd6,
        DI = 3'd7
    } RegisterEnum;

    function automatic logic [1:0] modrm_mod(input logic [7:0] b);
        return b[7:6];
    endfunction

    function automatic logic [2:0] modrm_reg(input logic [7:0] b);
        return b[5:3];
    endfunction

    function automatic logic [2:0] modrm_rm(input logic [7:0] b);
        return b[2:0];
    endfunction

    // Displacement bytes following the ModR/M byte; mod=00 rm=110 is a direct address
    function automatic logic [1:0] disp_bytes(input logic [1:0] mod_bits, input logic [2:0] rm);
        case (mod_bits)
            2'b01:   return 2'd1;
            2'b10:   return 2'd2;
            2'b00:   return (rm == 3'b110) ? 2'd2 : 2'd0;
            default: return 2'd0;
        endcase
    endfunction

    function automatic RegisterEnum base_reg(input logic [2:0] rm);
        case (rm)
            3'b000, 3'b001, 3'b111: return BX;
            3'b100:                 return SI;
            3'b101:                 return DI;
            default:                return BP;
        endcase
    endfunction

    function automatic RegisterEnum index_reg(input logic [2:0] rm);
        case (rm)
            3'b000, 3'b010: return SI;
            3'b001, 3'b011: return DI;
            default:        return AX;
        endcase
    endfunction

endpackage

// File: rtl/modrm_ea_unit_if.sv
// rtl/modrm_ea_unit_if.sv - prefetch FIFO and register-file read port bundle
interface modrm_ea_unit_if #(
    parameter int ADDR_W = 16
);
    logic              fifo_rd_en;
    logic [7:0]        fifo_rd_data;
    logic              fifo_empty;
    logic [2:0]        reg_sel0;
    logic [2:0]        reg_sel1;
    logic [ADDR_W-1:0] regs0;
    logic [ADDR_W-1:0] regs1;

    modport master (
        output fifo_rd_en, reg_sel0, reg_sel1,
        input  fifo_rd_data, fifo_empty, regs0, regs1
    );

    modport slave (
        input  fifo_rd_en, reg_sel0, reg_sel1,
        output fifo_rd_data, fifo_empty, regs0, regs1
    );
endinterface

// File: rtl/modrm_ea_calc.sv
// rtl/modrm_ea_calc.sv - combinational effective address and default segment
module modrm_ea_calc
    import modrm_ea_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [1:0]        mod_bits,
    input  logic [2:0]        rm,
    input  logic [ADDR_W-1:0] regs0,
    input  logic [ADDR_W-1:0] regs1,
    input  logic [15:0]       disp,
    output logic [ADDR_W-1:0] ea,
    output seg_e              default_seg
);
    logic signed [15:0] disp_s;
    logic [ADDR_W-1:0]  disp_ext;

    assign disp_s   = disp;
    assign disp_ext = ADDR_W'(disp_s);

    // Address sum wraps naturally at ADDR_W bits
    always_comb begin
        ea = regs0 + disp_ext;
        if (rm[2] == 1'b0)
            ea = regs0 + regs1 + disp_ext;
        else if (rm == 3'b110 && mod_bits == 2'b00)
            ea = disp_ext;
    end

    // BP-based forms default to the stack segment
    always_comb begin
        default_seg = SEG_DS;
        if (mod_bits != 2'b11) begin
            if (rm == 3'b010 || rm == 3'b011)
                default_seg = SEG_SS;
            else if (rm == 3'b110 && mod_bits != 2'b00)
                default_seg = SEG_SS;
        end
    end
endmodule

// File: rtl/modrm_ea_unit.sv
// rtl/modrm_ea_unit.sv - ModR/M fetch FSM with registered effective address
module modrm_ea_unit
    import modrm_ea_unit_pkg::*;
#(
    parameter int ADDR_W            = 16,
    parameter bit SIGN_EXTEND_DISP8 = 1'b1,
    parameter int REG_LATENCY       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    output logic              busy,
    output logic              complete,
    modrm_ea_unit_if.master   bus,
    output logic [ADDR_W-1:0] effective_address,
    output logic [15:0]       displacement,
    output logic [2:0]        regnum,
    output logic [2:0]        rm_regnum,
    output logic              rm_is_reg,
    output logic [1:0]        default_seg
);
    localparam logic CALC_LAST = (REG_LATENCY != 0);

    state_e            state;
    logic              pending;
    logic [1:0]        mod_q;
    logic [2:0]        rm_q;
    logic [1:0]        need_q;
    logic              calc_cnt;
    RegisterEnum       reg_sel0_q;
    RegisterEnum       reg_sel1_q;
    logic              fetch_state;
    logic [7:0]        byte_in;
    logic [15:0]       disp8_ext;
    logic [ADDR_W-1:0] calc_ea;
    seg_e              calc_seg;

    assign byte_in      = bus.fifo_rd_data;
    assign disp8_ext    = SIGN_EXTEND_DISP8 ? {{8{byte_in[7]}}, byte_in} : {8'h00, byte_in};
    assign fetch_state  = (state == MODRM) || (state == DISP_LO) || (state == DISP_HI);
    // Flush suppresses the pop so no byte is lost from the FIFO on abort
    assign bus.fifo_rd_en = fetch_state && !bus.fifo_empty && !pending && !flush;
    assign bus.reg_sel0 = reg_sel0_q;
    assign bus.reg_sel1 = reg_sel1_q;
    assign busy         = (state != IDLE);

    modrm_ea_calc #(.ADDR_W(ADDR_W)) u_calc (
        .mod_bits    (mod_q),
        .rm          (rm_q),
        .regs0       (bus.regs0),
        .regs1       (bus.regs1),
        .disp        (displacement),
        .ea          (calc_ea),
        .default_seg (calc_seg)
    );

    // Decode FSM: one byte per fetch state, captured the cycle after its pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            pending           <= 1'b0;
            complete          <= 1'b0;
            mod_q             <= 2'b00;
            rm_q              <= 3'b000;
            need_q            <= 2'd0;
            calc_cnt          <= 1'b0;
            reg_sel0_q        <= AX;
            reg_sel1_q        <= AX;
            displacement      <= 16'h0000;
            effective_address <= '0;
            default_seg       <= 2'd0;
            regnum            <= 3'd0;
            rm_regnum         <= 3'd0;
            rm_is_reg         <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            pending  <= 1'b0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            if (bus.fifo_rd_en)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (start)
                        state <= MODRM;
                end
                MODRM: begin
                    if (pending) begin
                        pending      <= 1'b0;
                        mod_q        <= modrm_mod(byte_in);
                        rm_q         <= modrm_rm(byte_in);
                        need_q       <= disp_bytes(modrm_mod(byte_in), modrm_rm(byte_in));
                        regnum       <= modrm_reg(byte_in);
                        rm_regnum    <= modrm_rm(byte_in);
                        rm_is_reg    <= (modrm_mod(byte_in) == 2'b11);
                        reg_sel0_q   <= base_reg(modrm_rm(byte_in));
                        reg_sel1_q   <= index_reg(modrm_rm(byte_in));
                        displacement <= 16'h0000;
                        calc_cnt     <= 1'b0;
                        if (modrm_mod(byte_in) == 2'b11) begin
                            state       <= DONE;
                            complete    <= 1'b1;
                            default_seg <= SEG_DS;
                        end else if (disp_bytes(modrm_mod(byte_in), modrm_rm(byte_in)) != 2'd0) begin
                            state <= DISP_LO;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                DISP_LO: begin
                    if (pending) begin
                        pending      <= 1'b0;
                        displacement <= disp8_ext;
                        state        <= (need_q == 2'd2) ? DISP_HI : CALC;
                    end
                end
                DISP_HI: begin
                    if (pending) begin
                        pending           <= 1'b0;
                        displacement[15:8] <= byte_in;
                        state             <= CALC;
                    end
                end
                CALC: begin
                    if (calc_cnt == CALC_LAST) begin
                        effective_address <= calc_ea;
                        default_seg       <= calc_seg;
                        complete          <= 1'b1;
                        state             <= DONE;
                    end else begin
                        calc_cnt <= calc_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
